// File: rtl/rotate_shift_pipe_if.sv
// rotate_shift_pipe_if: valid/ready stream bundle for rotate_shift_pipe.
// ROTATE_SHIFT_FLAGS_EN adds the out_zero/out_sticky result flags.
interface rotate_shift_pipe_if #(
    parameter int WIDTH = 8
) ();
    localparam int SW = $clog2(WIDTH);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SW-1:0]    in_shamt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef ROTATE_SHIFT_FLAGS_EN
    logic             out_zero;
    logic             out_sticky;
    modport master (
        output in_valid, in_data, in_shamt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_sticky
    );
    modport slave (
        input  in_valid, in_data, in_shamt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_sticky
    );
`else
    modport master (
        output in_valid, in_data, in_shamt, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, in_shamt, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/rotate_shift_pipe.sv
// rotate_shift_pipe: pipelined ROR/ROL/SRL/SRA barrel shifter, one stage per shift-amount bit.
// ROTATE_SHIFT_FLAGS_EN adds registered out_zero and out_sticky flags.
module rotate_shift_pipe #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    rotate_shift_pipe_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    logic w_adv;
    logic w_unused;
    // single global stall: every stage holds while the output is blocked
    assign w_adv        = !bus.out_valid | bus.out_ready;
    assign bus.in_ready = w_adv;
    for (genvar k = 0; k < SW; k++) begin : g_stage
        localparam int N = 1 << k;
        logic [WIDTH-1:0] r_data;
        logic [SW-1:0]    r_shamt;
        logic [1:0]       r_mode;
        logic             r_valid;
        logic             r_sign;
        logic [WIDTH-1:0] w_d;
        logic [WIDTH-1:0] w_shift;
        logic [WIDTH-1:0] w_res;
        logic [SW-1:0]    w_sh;
        logic [1:0]       w_m;
        logic             w_v;
        logic             w_s;
        logic             w_unused_sh;
        if (k == 0) begin : g_in
            assign w_d  = bus.in_data;
            assign w_sh = bus.in_shamt;
            assign w_m  = bus.in_mode;
            assign w_v  = bus.in_valid;
            assign w_s  = bus.in_data[WIDTH-1];
        end else begin : g_link
            assign w_d  = g_stage[k-1].r_data;
            assign w_sh = g_stage[k-1].r_shamt;
            assign w_m  = g_stage[k-1].r_mode;
            assign w_v  = g_stage[k-1].r_valid;
            assign w_s  = g_stage[k-1].r_sign;
        end
        assign w_unused_sh = ^w_sh;
        // right shifts fill with the sign captured at entry (zero for SRL)
        assign w_shift = (w_m == 2'b00) ? {w_d[N-1:0], w_d[WIDTH-1:N]} :
                         (w_m == 2'b01) ? {w_d[WIDTH-N-1:0], w_d[WIDTH-1:WIDTH-N]} :
                                          {{N{w_m[0] & w_s}}, w_d[WIDTH-1:N]};
        assign w_res = w_sh[k] ? w_shift : w_d;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_data  <= '0;
                r_shamt <= '0;
                r_mode  <= '0;
                r_sign  <= 1'b0;
            end else if (w_adv) begin
                r_valid <= w_v;
                r_data  <= w_res;
                r_shamt <= w_sh;
                r_mode  <= w_m;
                r_sign  <= w_s;
            end
        end
`ifdef ROTATE_SHIFT_FLAGS_EN
        logic r_sticky;
        logic w_st;
        if (k == 0) begin : g_st_in
            assign w_st = 1'b0;
        end else begin : g_st_link
            assign w_st = g_stage[k-1].r_sticky;
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_sticky <= 1'b0;
            else if (w_adv) r_sticky <= w_st | (w_m[1] & w_sh[k] & (|w_d[N-1:0]));
        end
`endif
    end
    assign bus.out_valid = g_stage[SW-1].r_valid;
    assign bus.out_data  = g_stage[SW-1].r_data;
    assign w_unused      = ^{g_stage[SW-1].r_shamt, g_stage[SW-1].r_mode, g_stage[SW-1].r_sign};
`ifdef ROTATE_SHIFT_FLAGS_EN
    logic r_zero;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_zero <= 1'b0;
        else if (w_adv) r_zero <= (g_stage[SW-1].w_res == '0);
    end
    assign bus.out_zero   = r_zero;
    assign bus.out_sticky = g_stage[SW-1].r_sticky;
`endif
endmodule
